// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl
// Oversampled SPI slave with the whole design in the sys_clk domain.
// The SS, SCK and MOSI pins are synchronized, and SCK edges are detected
// from the synchronized samples. All four CPOL/CPHA modes are supported,
// and words may run back to back while SS stays low.
//
// Ports:
//   sys_clk, rst_n        system clock, asynchronous active-low reset
//   cpol, cpha            SPI mode, latched only while idle
//   SS, SCK, MOSI         asynchronous SPI pins from the master
//   MISO, miso_oe         slave data out and its drive enable
//   tx_data/valid/ready   one-entry transmit holding register
//   rx_data/valid/ready   received word, held until accepted
//   rx_overrun            pulse: word finished while rx_data still unread
//   tx_underrun           pulse: shifter loaded while TX register empty
//   busy                  transfer in progress (FSM ACTIVE)
module spi_slave_ctrl #(
  parameter int DATA_LENGTH = 8,
  parameter int MSB_FIRST   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   sys_clk,
  input  logic                   rst_n,
  input  logic                   cpol,
  input  logic                   cpha,
  input  logic                   SS,
  input  logic                   SCK,
  input  logic                   MOSI,
  output logic                   MISO,
  output logic                   miso_oe,
  input  logic [DATA_LENGTH-1:0] tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [DATA_LENGTH-1:0] rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   rx_overrun,
  output logic                   tx_underrun,
  output logic                   busy
);

  localparam int CW = $clog2(DATA_LENGTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_LENGTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t r_state, w_nextState;

  logic [SYNC_STAGES-1:0] r_ssSync, r_sckSync, r_mosiSync, r_flush;
  logic                   r_ssPrev, r_sckPrev;
  logic [1:0]             r_mode;
  logic [CW-1:0]          r_bitCnt;
  logic [DATA_LENGTH-1:0] r_txShift, r_rxShift, r_txData, r_rxData;
  logic                   r_txReady, r_rxValid, r_rxOverrun, r_txUnderrun;

  logic w_ss, w_sck, w_mosi, w_ssFall, w_sckRise, w_sckFall;
  logic w_leadEdge, w_trailEdge, w_sampleEdge, w_shiftEdge;
  logic w_active, w_enter, w_sample, w_complete, w_load, w_advance, w_txBit;
  logic [DATA_LENGTH-1:0] w_rxNext, w_txNext;

  // Pin synchronizers and edge-history flops.
  // r_flush marks the point where the synchronizer chains hold real pin
  // values again after reset. Until then r_ssPrev is held low. As a result,
  // an SS line that was already low through reset never shows up as a
  // falling edge. The master must raise SS and lower it again first.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ssSync   <= '1;
      r_sckSync  <= '0;
      r_mosiSync <= '0;
      r_flush    <= '0;
      r_ssPrev   <= 1'b0;
      r_sckPrev  <= 1'b0;
    end else begin
      r_ssSync   <= {r_ssSync[SYNC_STAGES-2:0], SS};
      r_sckSync  <= {r_sckSync[SYNC_STAGES-2:0], SCK};
      r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], MOSI};
      r_flush    <= {r_flush[SYNC_STAGES-2:0], 1'b1};
      r_ssPrev   <= r_flush[SYNC_STAGES-1] & w_ss;
      r_sckPrev  <= w_sck;
    end
  end

  assign w_ss      = r_ssSync[SYNC_STAGES-1];
  assign w_sck     = r_sckSync[SYNC_STAGES-1];
  assign w_mosi    = r_mosiSync[SYNC_STAGES-1];
  assign w_ssFall  = r_ssPrev & ~w_ss;
  assign w_sckRise = w_sck & ~r_sckPrev;
  assign w_sckFall = ~w_sck & r_sckPrev;

  // The leading edge moves SCK away from its idle (cpol) level.
  // cpha then selects which of the two edges samples data.
  assign w_leadEdge   = r_mode[1] ? w_sckFall : w_sckRise;
  assign w_trailEdge  = r_mode[1] ? w_sckRise : w_sckFall;
  assign w_sampleEdge = r_mode[0] ? w_trailEdge : w_leadEdge;
  assign w_shiftEdge  = r_mode[0] ? w_leadEdge : w_trailEdge;

  assign w_active   = (r_state == ACTIVE);
  assign w_enter    = ~w_active & w_ssFall;
  assign w_sample   = w_active & ~w_ss & w_sampleEdge;
  assign w_complete = w_sample & (r_bitCnt == LAST_BIT);
  assign w_load     = w_enter | w_complete;
  // A shift edge with bit_cnt = 0 belongs to no word bit. This covers the
  // first leading edge in cpha=1 and the trailing edge after each word.
  assign w_advance  = w_active & ~w_ss & w_shiftEdge & (r_bitCnt != '0);

  generate
    if (MSB_FIRST != 0) begin : g_msbFirst
      assign w_rxNext = {r_rxShift[DATA_LENGTH-2:0], w_mosi};
      assign w_txNext = {r_txShift[DATA_LENGTH-2:0], 1'b0};
      assign w_txBit  = r_txShift[DATA_LENGTH-1];
    end else begin : g_lsbFirst
      assign w_rxNext = {w_mosi, r_rxShift[DATA_LENGTH-1:1]};
      assign w_txNext = {1'b0, r_txShift[DATA_LENGTH-1:1]};
      assign w_txBit  = r_txShift[0];
    end
  endgenerate

  // State register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state logic.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_ssFall) w_nextState = ACTIVE;
      ACTIVE:  if (w_ss)     w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy    = w_active;
    miso_oe = ~w_ss;
    MISO    = w_active & w_txBit;
  end

  // Datapath: mode latch, TX holding register, shifters, bit counter and
  // the RX handshake.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode       <= 2'b00;
      r_bitCnt     <= '0;
      r_txShift    <= '0;
      r_rxShift    <= '0;
      r_txData     <= '0;
      r_rxData     <= '0;
      r_txReady    <= 1'b1;
      r_rxValid    <= 1'b0;
      r_rxOverrun  <= 1'b0;
      r_txUnderrun <= 1'b0;
    end else begin
      r_rxOverrun  <= 1'b0;
      r_txUnderrun <= 1'b0;

      if (!w_active) r_mode <= {cpol, cpha};

      // A load from a full register frees it. When the register is already
      // empty, a capture in the same cycle still takes the new word, while
      // the load receives zeros.
      if (w_load && !r_txReady) begin
        r_txReady <= 1'b1;
      end else if (tx_valid && r_txReady) begin
        r_txData  <= tx_data;
        r_txReady <= 1'b0;
      end

      if (w_load) begin
        if (!r_txReady) begin
          r_txShift <= r_txData;
        end else begin
          r_txShift    <= '0;
          r_txUnderrun <= 1'b1;
        end
      end else if (w_advance) begin
        r_txShift <= w_txNext;
      end

      if (w_enter || (w_active && w_ss)) begin
        r_bitCnt <= '0;
      end else if (w_sample) begin
        r_rxShift <= w_rxNext;
        r_bitCnt  <= w_complete ? '0 : r_bitCnt + 1'b1;
      end

      if (w_complete) begin
        if (!r_rxValid || rx_ready) begin
          r_rxData  <= w_rxNext;
          r_rxValid <= 1'b1;
        end else begin
          r_rxOverrun <= 1'b1;
        end
      end else if (r_rxValid && rx_ready) begin
        r_rxValid <= 1'b0;
      end
    end
  end

  assign tx_ready    = r_txReady;
  assign rx_data     = r_rxData;
  assign rx_valid    = r_rxValid;
  assign rx_overrun  = r_rxOverrun;
  assign tx_underrun = r_txUnderrun;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb_spi_slave_ctrl
// Directed bench for spi_slave_ctrl. It builds two instances: dutM shifts
// MSB first and dutL shifts LSB first. Both share the SPI pins. The unused
// instance has its SS held high, and useLsb routes the active instance's
// outputs to the checks. A bit-banged master task drives SCK/MOSI and
// collects MISO.
module tb_spi_slave_ctrl;

  localparam int HALF  = 8;
  localparam int SETUP = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, cpol, cpha, ss, sck, mosi, txValid, rxReady, useLsb;
  logic [7:0] txData;

  logic       ssM, ssL, txValidM, txValidL;
  logic       misoM, oeM, txReadyM, rxValidM, ovM, unM, busyM;
  logic       misoL, oeL, txReadyL, rxValidL, ovL, unL, busyL;
  logic [7:0] rxDataM, rxDataL;

  logic       miso, oe, txReady, rxValid, rxOverrun, txUnderrun, busy;
  logic [7:0] rxData;

  assign ssM      = useLsb ? 1'b1 : ss;
  assign ssL      = useLsb ? ss : 1'b1;
  assign txValidM = ~useLsb & txValid;
  assign txValidL = useLsb & txValid;

  assign miso       = useLsb ? misoL    : misoM;
  assign oe         = useLsb ? oeL      : oeM;
  assign txReady    = useLsb ? txReadyL : txReadyM;
  assign rxValid    = useLsb ? rxValidL : rxValidM;
  assign rxOverrun  = useLsb ? ovL      : ovM;
  assign txUnderrun = useLsb ? unL      : unM;
  assign busy       = useLsb ? busyL    : busyM;
  assign rxData     = useLsb ? rxDataL  : rxDataM;

  spi_slave_ctrl #(.DATA_LENGTH(8), .MSB_FIRST(1), .SYNC_STAGES(2)) dutM (
    .sys_clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha),
    .SS(ssM), .SCK(sck), .MOSI(mosi), .MISO(misoM), .miso_oe(oeM),
    .tx_data(txData), .tx_valid(txValidM), .tx_ready(txReadyM),
    .rx_data(rxDataM), .rx_valid(rxValidM), .rx_ready(rxReady),
    .rx_overrun(ovM), .tx_underrun(unM), .busy(busyM)
  );

  spi_slave_ctrl #(.DATA_LENGTH(8), .MSB_FIRST(0), .SYNC_STAGES(2)) dutL (
    .sys_clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha),
    .SS(ssL), .SCK(sck), .MOSI(mosi), .MISO(misoL), .miso_oe(oeL),
    .tx_data(txData), .tx_valid(txValidL), .tx_ready(txReadyL),
    .rx_data(rxDataL), .rx_valid(rxValidL), .rx_ready(rxReady),
    .rx_overrun(ovL), .tx_underrun(unL), .busy(busyL)
  );

  int checks   = 0;
  int failures = 0;

  // Pulse and event monitor. It samples on the falling edge, away from the
  // edge that updates the DUT.
  int         ovCount = 0, unCount = 0, rxRiseCount = 0;
  logic       rxValidPrev = 1'b0;
  logic [7:0] rxLog[$];
  always @(negedge clk) begin
    if (rxOverrun === 1'b1)  ovCount++;
    if (txUnderrun === 1'b1) unCount++;
    if (rxValid === 1'b1 && rxValidPrev !== 1'b1) begin
      rxRiseCount++;
      rxLog.push_back(rxData);
    end
    rxValidPrev = rxValid;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits, with a bound, for the selected instance's TX register to be
  // free, then presents one word for a single cycle.
  task automatic writeTx(input logic [7:0] d);
    int n;
    n = 0;
    while (txReady !== 1'b1 && n < 500) begin
      waitCycles(1);
      n++;
    end
    checkOutput("txReadyWait", {31'd0, txReady}, 32'd1);
    txData  = d;
    txValid = 1'b1;
    waitCycles(1);
    txValid = 1'b0;
  endtask

  // Bit-banged master for nBits bits of one word. The bit order follows
  // useLsb, and cpol/cpha set the SCK pattern.
  task automatic applyStimulus(input logic [7:0] mo, input int nBits, output logic [7:0] mi);
    int idx;
    mi = 8'h00;
    for (int i = 0; i < nBits; i++) begin
      idx = useLsb ? i : 7 - i;
      if (!cpha) begin
        mosi = mo[idx];
        waitCycles(HALF);
        mi[idx] = miso;
        sck = ~cpol;
        waitCycles(HALF);
        sck = cpol;
      end else begin
        sck  = ~cpol;
        mosi = mo[idx];
        waitCycles(HALF);
        mi[idx] = miso;
        sck = cpol;
        waitCycles(HALF);
      end
    end
  endtask

  task automatic clearRx();
    rxReady = 1'b1;
    waitCycles(1);
    rxReady = 1'b0;
    waitCycles(1);
  endtask

  logic [7:0] got, got2;
  int         unBase, ovBase, riseBase, logBase;

  initial begin
    rst_n = 1'b0; cpol = 1'b0; cpha = 1'b0; ss = 1'b1; sck = 1'b0; mosi = 1'b0;
    txData = 8'h00; txValid = 1'b0; rxReady = 1'b0; useLsb = 1'b0;
    waitCycles(3);

    // Reset state
    checkOutput("rstMiso",    {31'd0, miso},    32'd0);
    checkOutput("rstOe",      {31'd0, oe},      32'd0);
    checkOutput("rstTxReady", {31'd0, txReady}, 32'd1);
    checkOutput("rstRxData",  {24'd0, rxData},  32'd0);
    checkOutput("rstRxValid", {31'd0, rxValid}, 32'd0);
    checkOutput("rstBusy",    {31'd0, busy},    32'd0);
    rst_n = 1'b1;
    waitCycles(SETUP);

    // Mode 0, MSB first: slave sends 0x3C, master sends 0xA5
    writeTx(8'h3C);
    unBase = unCount; ovBase = ovCount;
    ss = 1'b0;
    waitCycles(SETUP);
    checkOutput("t1Busy", {31'd0, busy}, 32'd1);
    checkOutput("t1Oe",   {31'd0, oe},   32'd1);
    checkOutput("t1NoUnderrunAtLoad", unCount - unBase, 32'd0);
    applyStimulus(8'hA5, 8, got);
    waitCycles(SETUP);
    ss = 1'b1;
    waitCycles(SETUP);
    checkOutput("t1MasterRx", {24'd0, got},     32'h3C);
    checkOutput("t1RxData",   {24'd0, rxData},  32'hA5);
    checkOutput("t1RxValid",  {31'd0, rxValid}, 32'd1);
    checkOutput("t1Busy0",    {31'd0, busy},    32'd0);
    checkOutput("t1Overrun",  ovCount - ovBase, 32'd0);
    waitCycles(20);
    checkOutput("t1RxValidHeld", {31'd0, rxValid}, 32'd1);
    clearRx();
    checkOutput("t1RxValidClr", {31'd0, rxValid}, 32'd0);

    // Mode 3, LSB first (dutL): same data
    useLsb = 1'b1; cpol = 1'b1; cpha = 1'b1; sck = 1'b1;
    waitCycles(SETUP);
    writeTx(8'h3C);
    ovBase = ovCount;
    ss = 1'b0;
    waitCycles(SETUP);
    applyStimulus(8'hA5, 8, got);
    waitCycles(SETUP);
    ss = 1'b1;
    waitCycles(SETUP);
    checkOutput("t2MasterRx", {24'd0, got},     32'h3C);
    checkOutput("t2RxData",   {24'd0, rxData},  32'hA5);
    checkOutput("t2RxValid",  {31'd0, rxValid}, 32'd1);
    checkOutput("t2Overrun",  ovCount - ovBase, 32'd0);
    clearRx();
    useLsb = 1'b0; cpol = 1'b0; cpha = 1'b0; sck = 1'b0;
    waitCycles(SETUP);

    // Continuous: two words in one SS, second TX word written once freed
    rxReady = 1'b1;
    writeTx(8'h11);
    riseBase = rxRiseCount; logBase = rxLog.size(); ovBase = ovCount;
    ss = 1'b0;
    fork
      writeTx(8'h22);
      begin
        waitCycles(SETUP);
        applyStimulus(8'h81, 8, got);
        applyStimulus(8'h42, 8, got2);
      end
    join
    waitCycles(SETUP);
    ss = 1'b1;
    waitCycles(SETUP);
    rxReady = 1'b0;
    checkOutput("t3MasterRx0", {24'd0, got},  32'h11);
    checkOutput("t3MasterRx1", {24'd0, got2}, 32'h22);
    checkOutput("t3RxPulses",  rxRiseCount - riseBase, 32'd2);
    checkOutput("t3Word0", (rxLog.size() > logBase)     ? {24'd0, rxLog[logBase]}     : 32'hDEAD, 32'h81);
    checkOutput("t3Word1", (rxLog.size() > logBase + 1) ? {24'd0, rxLog[logBase + 1]} : 32'hDEAD, 32'h42);
    checkOutput("t3Overrun", ovCount - ovBase, 32'd0);
    checkOutput("t3RxValid", {31'd0, rxValid}, 32'd0);

    // Abort after 5 bits, then a transfer with an empty TX register
    writeTx(8'h77);
    riseBase = rxRiseCount;
    ss = 1'b0;
    waitCycles(SETUP);
    applyStimulus(8'hFF, 5, got);
    waitCycles(SETUP);
    ss = 1'b1;
    waitCycles(SETUP);
    checkOutput("t4AbortBusy",    {31'd0, busy},    32'd0);
    checkOutput("t4AbortNoRx",    rxRiseCount - riseBase, 32'd0);
    checkOutput("t4AbortTxReady", {31'd0, txReady}, 32'd1);
    unBase = unCount;
    ss = 1'b0;
    waitCycles(SETUP);
    checkOutput("t4UnderrunOnce", unCount - unBase, 32'd1);
    applyStimulus(8'h96, 8, got);
    waitCycles(SETUP);
    ss = 1'b1;
    waitCycles(SETUP);
    checkOutput("t4MasterRx", {24'd0, got},     32'h00);
    checkOutput("t4RxData",   {24'd0, rxData},  32'h96);
    checkOutput("t4RxValid",  {31'd0, rxValid}, 32'd1);
    clearRx();

    // Overrun: two words with rx_ready low
    ovBase = ovCount;
    ss = 1'b0;
    waitCycles(SETUP);
    applyStimulus(8'h12, 8, got);
    applyStimulus(8'h34, 8, got);
    waitCycles(SETUP);
    ss = 1'b1;
    waitCycles(SETUP);
    checkOutput("t5RxDataKept", {24'd0, rxData},  32'h12);
    checkOutput("t5RxValid",    {31'd0, rxValid}, 32'd1);
    checkOutput("t5OverrunOnce", ovCount - ovBase, 32'd1);
    clearRx();

    // Reset after bit 4 with SS held low
    ss = 1'b0;
    waitCycles(SETUP);
    applyStimulus(8'hF0, 4, got);
    rst_n = 1'b0;
    #2;
    checkOutput("t6Miso",    {31'd0, miso},    32'd0);
    checkOutput("t6Oe",      {31'd0, oe},      32'd0);
    checkOutput("t6TxReady", {31'd0, txReady}, 32'd1);
    checkOutput("t6RxData",  {24'd0, rxData},  32'd0);
    checkOutput("t6RxValid", {31'd0, rxValid}, 32'd0);
    checkOutput("t6Busy",    {31'd0, busy},    32'd0);
    waitCycles(3);
    rst_n = 1'b1;
    sck = 1'b0;
    waitCycles(SETUP + 5);
    checkOutput("t6StayIdle", {31'd0, busy}, 32'd0);
    checkOutput("t6OeLow",    {31'd0, oe},   32'd1);
    ss = 1'b1;
    waitCycles(SETUP);
    writeTx(8'h5A);
    ss = 1'b0;
    waitCycles(SETUP);
    applyStimulus(8'hC3, 8, got);
    waitCycles(SETUP);
    ss = 1'b1;
    waitCycles(SETUP);
    checkOutput("t6MasterRx", {24'd0, got},     32'h5A);
    checkOutput("t6RxData",   {24'd0, rxData},  32'hC3);
    checkOutput("t6RxValid",  {31'd0, rxValid}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
